// File: rtl/serial_product_accumulator.sv
// rtl/serial_product_accumulator.sv - shift-add multiplier sequencer and product accumulator
//
// Purpose:
//   Sequences an upstream parallel-in/serial-out multiplier shift register.
//   The upstream register presents the multiplier LSB first on mult_bit.
//   For every 1 bit, the multiplicand, shifted to that bit's weight, is added
//   into a 2*WORD_LENGTH product. A one-cycle ready pulse marks the final product.
//
// Ports:
//   clk           in   1     system clock, rising edge
//   reset         in   1     asynchronous, active-low reset
//   start         in   1     request a new multiplication (honoured only when idle)
//   multiplicand  in   W     operand A, captured when start is accepted
//   mult_bit      in   1     serial multiplier bit from upstream, LSB first
//   load          out  1     upstream parallel-load strobe, one cycle
//   shift         out  1     upstream advance strobe; mult_bit is valid while high
//   product       out  2W    accumulated result; holds until the next accepted start
//   busy          out  1     high from start acceptance through the ready cycle
//   ready         out  1     one-cycle pulse: product is final

module serial_product_accumulator #(
  parameter int WORD_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic                     mult_bit,
  output logic                     load,
  output logic                     shift,
  output logic [2*WORD_LENGTH-1:0] product,
  output logic                     busy,
  output logic                     ready
);

  localparam int PW = 2 * WORD_LENGTH;
  // A single-bit word still needs a one-bit counter.
  localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] mcand_r;
  logic [CW-1:0] bit_cnt;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Outputs depend on state only, so no input
  // reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        shift = 1'b1;
        busy  = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and accumulation. The multiplicand is held zero-extended
  // to product width so the weighted add never needs a carry out: the largest
  // result, (2^W-1)^2, fits in 2W bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r <= '0;
      product <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_r <= {{WORD_LENGTH{1'b0}}, multiplicand};
            product <= '0;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          if (mult_bit) begin
            product <= product + (mcand_r << bit_cnt);
          end
          // Wrap explicitly so the counter stays within 0..W-1 even when W is
          // not a power of two.
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_product_accumulator.sv
// tb/tb_serial_product_accumulator.sv - scoreboard bench for serial_product_accumulator (W=4 and W=8)

module tb_serial_product_accumulator;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  // W=4 instance and its upstream shift register
  logic        start4, mbit4, load4, shift4, busy4, ready4;
  logic [3:0]  a4, b4, sr4;
  logic [7:0]  product4;
  exp_t        q4[$];
  int          ld4, sh4;
  logic        prev4, idle_chk4;

  // W=8 instance and its upstream shift register
  logic        start8, mbit8, load8, shift8, busy8, ready8;
  logic [7:0]  a8, b8, sr8;
  logic [15:0] product8;
  exp_t        q8[$];
  int          ld8, sh8;
  logic        prev8, idle_chk8;

  serial_product_accumulator #(.WORD_LENGTH(4)) dut4 (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start4),
    .multiplicand (a4),
    .mult_bit     (mbit4),
    .load         (load4),
    .shift        (shift4),
    .product      (product4),
    .busy         (busy4),
    .ready        (ready4)
  );

  serial_product_accumulator #(.WORD_LENGTH(8)) dut8 (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start8),
    .multiplicand (a8),
    .mult_bit     (mbit8),
    .load         (load8),
    .shift        (shift8),
    .product      (product8),
    .busy         (busy8),
    .ready        (ready8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream registers; outside shift cycles they present a 1 so that any
  // sampling of mult_bit outside RUN would corrupt the product.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr4 <= '0;
    else if (load4) sr4 <= b4;
    else if (shift4) sr4 <= sr4 >> 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr8 <= '0;
    else if (load8) sr8 <= b8;
    else if (shift8) sr8 <= sr8 >> 1;
  end
  assign mbit4 = shift4 ? sr4[0] : 1'b1;
  assign mbit8 = shift8 ? sr8[0] : 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the scoreboard on each ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ld4 = 0; sh4 = 0; prev4 = 1'b0; idle_chk4 = 1'b0;
    end else begin
      if (idle_chk4) begin
        check("busy_after_ready4", 32'(busy4), 32'd0);
        idle_chk4 = 1'b0;
      end
      if (load4) ld4++;
      if (shift4) sh4++;
      if (ready4) begin
        check("ready_width4", 32'(prev4), 32'd0);
        if (q4.size() == 0) begin
          check("unexpected_ready4", 32'(ready4), 32'd0);
        end else begin
          e = q4.pop_front();
          check("product4", 32'(product4), e.prod);
          check("ready_cycle4", cyc, e.cyc);
          check("shift_count4", sh4, 32'd4);
          check("load_count4", ld4, 32'd1);
        end
        ld4 = 0; sh4 = 0; idle_chk4 = 1'b1;
      end
      prev4 = ready4;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ld8 = 0; sh8 = 0; prev8 = 1'b0; idle_chk8 = 1'b0;
    end else begin
      if (idle_chk8) begin
        check("busy_after_ready8", 32'(busy8), 32'd0);
        idle_chk8 = 1'b0;
      end
      if (load8) ld8++;
      if (shift8) sh8++;
      if (ready8) begin
        check("ready_width8", 32'(prev8), 32'd0);
        if (q8.size() == 0) begin
          check("unexpected_ready8", 32'(ready8), 32'd0);
        end else begin
          e = q8.pop_front();
          check("product8", 32'(product8), e.prod);
          check("ready_cycle8", cyc, e.cyc);
          check("shift_count8", sh8, 32'd8);
          check("load_count8", ld8, 32'd1);
        end
        ld8 = 0; sh8 = 0; idle_chk8 = 1'b1;
      end
      prev8 = ready8;
    end
  end

  // One W=4 operation: start accepted at edge E, ready in the cycle after
  // edge E+5, next start accepted at edge E+7 when gap is 0.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input int gap);
    exp_t e;
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    e.prod = 32'(a) * 32'(b);
    e.cyc  = cyc + 5;
    q4.push_back(e);
    start4 = 1'b0;
    a4 = ~a;
    check("busy_at_load4", 32'(busy4), 32'd1);
    tick();
    b4 = ~b;
    repeat (5 + gap) tick();
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int gap);
    exp_t e;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    e.prod = 32'(a) * 32'(b);
    e.cyc  = cyc + 9;
    q8.push_back(e);
    start8 = 1'b0;
    a8 = ~a;
    check("busy_at_load8", 32'(busy8), 32'd1);
    tick();
    b8 = ~b;
    repeat (9 + gap) tick();
  endtask

  logic [3:0] held_a [3];
  logic [3:0] held_b [3];

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    held_a[0] = 4'h2; held_b[0] = 4'h3;
    held_a[1] = 4'h4; held_b[1] = 4'h4;
    held_a[2] = 4'hF; held_b[2] = 4'h1;

    repeat (3) tick();
    check("rst_product4", 32'(product4), 32'd0);
    check("rst_load4", 32'(load4), 32'd0);
    check("rst_shift4", 32'(shift4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_ready4", 32'(ready4), 32'd0);
    check("rst_product8", 32'(product8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed products, including an all-ones and a zero operand
    op4(4'hD, 4'hB, 0);
    check("hold_product4", 32'(product4), 32'h8F);
    tick();
    check("hold_product4_later", 32'(product4), 32'h8F);
    op4(4'hF, 4'hF, 1);
    op4(4'h0, 4'h9, 1);

    // Extra start pulses during RUN are ignored
    a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
    tick();
    e.prod = 32'h0F; e.cyc = cyc + 5;
    q4.push_back(e);
    start4 = 1'b0; a4 = 4'hC;
    tick();
    start4 = 1'b1;
    tick();
    tick();
    start4 = 1'b0;
    repeat (5) tick();
    check("ignored_start_product4", 32'(product4), 32'h0F);

    // Reset in the second RUN cycle aborts the operation without a ready pulse
    a4 = 4'h7; b4 = 4'h6; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_product4", 32'(product4), 32'd0);
    check("abort_busy4", 32'(busy4), 32'd0);
    check("abort_shift4", 32'(shift4), 32'd0);
    check("abort_ready4", 32'(ready4), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    op4(4'h7, 4'h6, 0);

    // start held high: back-to-back operations every 7 cycles
    start4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a4 = held_a[i]; b4 = held_b[i];
      tick();
      e.prod = 32'(held_a[i]) * 32'(held_b[i]);
      e.cyc  = cyc + 5;
      q4.push_back(e);
      tick();
      repeat (5) tick();
    end
    start4 = 1'b0;
    repeat (3) tick();

    // Random operands at both widths
    for (int i = 0; i < 500; i++) begin
      op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 500; i++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) tick();
    check("drain4", 32'(q4.size()), 32'd0);
    check("drain8", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
